// File: rtl/ldm_stm_sequencer_if.sv
// ldm_stm_sequencer_if
// Data-memory bus between the LDM/STM sequencer (master) and the memory (slave).
//
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and
// holds all of them unchanged until mem_ready is seen high. The transfer
// completes on the rising clock edge where mem_req & mem_ready are both 1.
// For a read, mem_rdata is valid in that same cycle. mem_ready may stay high
// while no request is pending; it has no meaning without mem_req.
//
// Signals:
//   mem_req   master->slave  transfer request
//   mem_we    master->slave  1 = write (STM), 0 = read (LDM)
//   mem_addr  master->slave  word address of the current transfer
//   mem_wdata master->slave  store data
//   mem_rdata slave->master  load data, valid when mem_ready
//   mem_ready slave->master  completes the pending transfer
interface ldm_stm_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Multi-cycle sequencer for ARM block transfers (LDM/STM). It walks the
// register list lowest register first, one register per memory handshake,
// owning the register file read port (stores) and its single write port
// (loads and base writeback). busy stalls the pipeline while it works.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle request, sampled only in IDLE
//   is_load     1 = LDM, 0 = STM
//   reg_list    bit i set = transfer Ri
//   base_rn     base register index
//   base_val    current base register value
//   up/pre/wback  ARM U, P and W bits
//   rf_src      register file read index (current register)
//   rf_rdata    register file read data (asynchronous read)
//   bus         data-memory master port (see ldm_stm_sequencer_if)
//   wb_en/wb_dest/wb_value  register file write port; the register file
//               writes on negedge, so these commit within the same cycle
//   busy        high in XFER and WB_BASE
//   done        one-cycle completion pulse
//   dbg_state   current FSM state (0 IDLE, 1 XFER, 2 WB_BASE, 3 DONE)
module ldm_stm_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          is_load,
  input  logic [REG_COUNT-1:0]          reg_list,
  input  logic [$clog2(REG_COUNT)-1:0]  base_rn,
  input  logic [DATA_WIDTH-1:0]         base_val,
  input  logic                          up,
  input  logic                          pre,
  input  logic                          wback,
  output logic [$clog2(REG_COUNT)-1:0]  rf_src,
  input  logic [DATA_WIDTH-1:0]         rf_rdata,
  ldm_stm_sequencer_if.master           bus,
  output logic                          wb_en,
  output logic [$clog2(REG_COUNT)-1:0]  wb_dest,
  output logic [DATA_WIDTH-1:0]         wb_value,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int CNT_W = $clog2(REG_COUNT + 1);
  localparam logic [DATA_WIDTH-1:0] WORD = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_WB_BASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched transfer context
  logic [REG_COUNT-1:0]  list_q;
  logic                  is_load_q;
  logic [IDX_W-1:0]      base_rn_q;
  logic                  wback_q;
  logic                  base_in_list_q;
  logic [DATA_WIDTH-1:0] cur_addr_q;
  logic [DATA_WIDTH-1:0] final_base_q;

  // Start-of-transfer arithmetic
  logic [CNT_W-1:0]      n_regs;
  logic [DATA_WIDTH-1:0] span;
  logic [DATA_WIDTH-1:0] start_addr;
  logic [DATA_WIDTH-1:0] final_base;

  // Per-transfer signals
  logic [IDX_W-1:0]      cur_reg;
  logic [REG_COUNT-1:0]  list_next;
  logic                  handshake;
  logic                  list_empty_next;
  logic                  do_base_wb;

  function automatic logic [CNT_W-1:0] popcount(input logic [REG_COUNT-1:0] l);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      c = c + CNT_W'(l[i]);
    end
    return c;
  endfunction

  always_comb begin
    n_regs = popcount(reg_list);
    span   = DATA_WIDTH'(n_regs) << 2;
    // Transfers always ascend in register order, so for decrementing modes
    // the walk starts at the low end of the block.
    case ({up, pre})
      2'b10:   start_addr = base_val;                 // IA
      2'b11:   start_addr = base_val + WORD;          // IB
      2'b00:   start_addr = base_val - span + WORD;   // DA
      default: start_addr = base_val - span;          // DB
    endcase
    final_base = up ? (base_val + span) : (base_val - span);
  end

  // Lowest set bit of the remaining list: scan high to low so the last hit wins.
  always_comb begin
    cur_reg = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (list_q[i]) cur_reg = IDX_W'(i);
    end
  end

  assign list_next       = list_q & ~(REG_COUNT'(1) << cur_reg);
  assign list_empty_next = (list_next == '0);
  assign handshake       = (state_q == ST_XFER) && bus.mem_ready;
  // A load into the base register owns the write; writeback would clobber it.
  assign do_base_wb      = wback_q && !(is_load_q && base_in_list_q);

  // State register and latched context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      list_q         <= '0;
      is_load_q      <= 1'b0;
      base_rn_q      <= '0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      cur_addr_q     <= '0;
      final_base_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        list_q         <= reg_list;
        is_load_q      <= is_load;
        base_rn_q      <= base_rn;
        wback_q        <= wback;
        base_in_list_q <= reg_list[base_rn];
        cur_addr_q     <= start_addr;
        final_base_q   <= final_base;
      end else if (handshake) begin
        list_q     <= list_next;
        cur_addr_q <= cur_addr_q + WORD;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (n_regs == '0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        if (handshake && list_empty_next) state_d = do_base_wb ? ST_WB_BASE : ST_DONE;
      end
      ST_WB_BASE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rf_src        = '0;
    wb_en         = 1'b0;
    wb_dest       = '0;
    wb_value      = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_XFER: begin
        busy          = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = !is_load_q;
        bus.mem_addr  = cur_addr_q;
        rf_src        = cur_reg;
        bus.mem_wdata = rf_rdata;
        if (is_load_q && bus.mem_ready) begin
          wb_en    = 1'b1;
          wb_dest  = cur_reg;
          wb_value = bus.mem_rdata;
        end
      end
      ST_WB_BASE: begin
        busy     = 1'b1;
        wb_en    = 1'b1;
        wb_dest  = base_rn_q;
        wb_value = final_base_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [15:0] reg_list;
  logic [3:0]  base_rn;
  logic [31:0] base_val;
  logic        up, pre, wback;
  logic [3:0]  rf_src;
  logic [31:0] rf_rdata;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        busy, done;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  ldm_stm_sequencer_if #(.DATA_WIDTH(32)) bus ();

  ldm_stm_sequencer #(.DATA_WIDTH(32), .REG_COUNT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_load  (is_load),
    .reg_list (reg_list),
    .base_rn  (base_rn),
    .base_val (base_val),
    .up       (up),
    .pre      (pre),
    .wback    (wback),
    .rf_src   (rf_src),
    .rf_rdata (rf_rdata),
    .bus      (bus),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_value (wb_value),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Register file model: Ri reads as C0DE_000i.
  assign rf_rdata = 32'hC0DE_0000 | {28'h0, rf_src};

  typedef struct {
    logic        is_load;
    logic [15:0] reg_list;
    logic [3:0]  base_rn;
    logic [31:0] base_val;
    logic        up, pre, wback;
    int          wait_k;     // transfer index that sees wait states
    int          wait_n;     // number of wait cycles on it
    bit          poke;       // pulse start with junk inputs while busy
    logic [31:0] exp_start;
    logic [31:0] exp_final;
    bit          exp_wb;
    int          exp_done;   // cycle in which done must assert
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [15:0] l);
    for (int i = 0; i < 16; i++) if (l[i]) return i;
    return 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, " mem_req"},  32'(bus.mem_req), 32'd0);
    chk({tag, " mem_we"},   32'(bus.mem_we), 32'd0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, " rf_src"},   32'(rf_src), 32'd0);
    chk({tag, " wb_en"},    32'(wb_en), 32'd0);
    chk({tag, " wb_dest"},  32'(wb_dest), 32'd0);
    chk({tag, " wb_value"}, wb_value, 32'd0);
    chk({tag, " busy"},     32'(busy), 32'd0);
    chk({tag, " done"},     32'(done), 32'd0);
  endtask

  // driver task: issues one block transfer and checks it cycle by cycle
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] rem;
    logic [31:0] addr;
    int          k, waits, cyc, cur;
    bit          wb_seen, finished;
    string       t;
    @(negedge clk);
    is_load  = v.is_load;
    reg_list = v.reg_list;
    base_rn  = v.base_rn;
    base_val = v.base_val;
    up       = v.up;
    pre      = v.pre;
    wback    = v.wback;
    start    = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rem      = v.reg_list;
    addr     = v.exp_start;
    k        = 0;
    waits    = v.wait_n;
    wb_seen  = 0;
    finished = 0;
    cyc      = 1;
    while (!finished && cyc <= 40) begin
      if (v.poke && cyc == 2) begin
        start    = 1'b1;
        is_load  = ~v.is_load;
        reg_list = 16'hFFFF;
        base_val = 32'hDEAD_BEEF;
      end
      if (v.poke && cyc == 3) start = 1'b0;
      if (rem != 16'h0) begin
        cur = lowest(rem);
        bus.mem_ready = (k == v.wait_k && waits > 0) ? 1'b0 : 1'b1;
        bus.mem_rdata = 32'h0000_00AA + 32'(k) * 32'h11;
        #1;
        t = $sformatf("v%0d c%0d", idx, cyc);
        chk({t, " busy"},     32'(busy), 32'd1);
        chk({t, " done"},     32'(done), 32'd0);
        chk({t, " mem_req"},  32'(bus.mem_req), 32'd1);
        chk({t, " mem_we"},   32'(bus.mem_we), 32'(!v.is_load));
        chk({t, " mem_addr"}, bus.mem_addr, addr);
        chk({t, " rf_src"},   32'(rf_src), 32'(cur));
        if (!v.is_load) begin
          chk({t, " mem_wdata"}, bus.mem_wdata, 32'hC0DE_0000 | 32'(cur));
          chk({t, " wb_en"}, 32'(wb_en), 32'd0);
        end else if (bus.mem_ready) begin
          chk({t, " wb_en"},    32'(wb_en), 32'd1);
          chk({t, " wb_dest"},  32'(wb_dest), 32'(cur));
          chk({t, " wb_value"}, wb_value, 32'h0000_00AA + 32'(k) * 32'h11);
        end else begin
          chk({t, " wb_en"}, 32'(wb_en), 32'd0);
        end
        if (bus.mem_ready) begin
          rem[cur] = 1'b0;
          addr     = addr + 32'd4;
          k++;
        end else begin
          waits--;
        end
      end else if (v.exp_wb && !wb_seen) begin
        #1;
        t = $sformatf("v%0d c%0d wb", idx, cyc);
        chk({t, " busy"},     32'(busy), 32'd1);
        chk({t, " mem_req"},  32'(bus.mem_req), 32'd0);
        chk({t, " wb_en"},    32'(wb_en), 32'd1);
        chk({t, " wb_dest"},  32'(wb_dest), 32'(v.base_rn));
        chk({t, " wb_value"}, wb_value, v.exp_final);
        wb_seen = 1;
      end else begin
        #1;
        t = $sformatf("v%0d c%0d done", idx, cyc);
        chk({t, " done"},    32'(done), 32'd1);
        chk({t, " busy"},    32'(busy), 32'd0);
        chk({t, " mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({t, " wb_en"},   32'(wb_en), 32'd0);
        chk({t, " cycle"},   32'(cyc), 32'(v.exp_done));
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d finished", idx), 32'(finished), 32'd1);
    #1;
    chk($sformatf("v%0d done cleared", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    // stimulus table: {is_load, list, rn, base, U, P, W, wait_k, wait_n, poke,
    //                  exp_start, exp_final, exp_wb, exp_done}
    vecs[0] = '{1'b0, 16'h000E, 4'd13, 32'h0000_0100, 1'b1, 1'b0, 1'b1, -1, 0, 0,
                32'h0000_0100, 32'h0000_010C, 1, 5};   // STM IA
    vecs[1] = '{1'b1, 16'h8001, 4'd3,  32'h0000_0200, 1'b0, 1'b1, 1'b0, -1, 0, 0,
                32'h0000_01F8, 32'h0000_01F8, 0, 3};   // LDM DB
    vecs[2] = '{1'b1, 16'h0006, 4'd2,  32'h0000_0100, 1'b1, 1'b1, 1'b1, -1, 0, 0,
                32'h0000_0104, 32'h0000_0108, 0, 3};   // LDM IB, Rn in list
    vecs[3] = '{1'b0, 16'h0016, 4'd0,  32'h0000_0400, 1'b1, 1'b0, 1'b0, 1, 3, 0,
                32'h0000_0400, 32'h0000_040C, 0, 7};   // STM, waits on 2nd
    vecs[4] = '{1'b0, 16'h0000, 4'd5,  32'h0000_0050, 1'b1, 1'b0, 1'b1, -1, 0, 0,
                32'h0000_0050, 32'h0000_0050, 0, 1};   // empty list
    vecs[5] = '{1'b0, 16'h0021, 4'd5,  32'h0000_1000, 1'b0, 1'b0, 1'b1, -1, 0, 1,
                32'h0000_0FFC, 32'h0000_0FF8, 1, 4};   // STM DA, start while busy
    vecs[6] = '{1'b0, 16'hFFFF, 4'd4,  32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, -1, 0, 0,
                32'hFFFF_FFF8, 32'h0000_0038, 1, 18};  // full list, wrap
    vecs[7] = '{1'b1, 16'h0003, 4'd9,  32'h0000_0004, 1'b0, 1'b1, 1'b1, -1, 0, 0,
                32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 4};   // LDM DB, wrap below 0

    rst = 1'b1; start = 1'b0; is_load = 1'b0; reg_list = '0; base_rn = '0;
    base_val = '0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of a 4-register STM, then a clean rerun.
    @(negedge clk);
    is_load = 1'b0; reg_list = 16'h00F0; base_rn = 4'd1; base_val = 32'h0000_0800;
    up = 1'b1; pre = 1'b0; wback = 1'b1; start = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("midrst xfer mem_req", 32'(bus.mem_req), 32'd1);
    chk("midrst xfer mem_addr", bus.mem_addr, 32'h0000_0800);
    chk("midrst xfer rf_src", 32'(rf_src), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("midrst idle");
    run_vec(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
